// File: rtl/env_loader_if.sv
// Byte-stream valid/ready channel feeding the task-memory loader.
interface env_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/env_loader.sv
// Frames a byte stream into a shadow buffer and, after a checksum match,
// commits it in one cycle to the flat task-memory bus.
module env_loader #(
    parameter int unsigned TM_BYTES = 256,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    env_loader_if.slave           s_in,
    output logic [TM_BYTES*8-1:0] env_task_memory,
    output logic                  loaded,
    output logic                  load_pulse,
    output logic                  err_pulse,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int unsigned PtrW = $clog2(TM_BYTES);
    localparam int unsigned IdxW = $clog2(TM_BYTES * 8);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StPayload,
        StCheck,
        StCommit
    } state_t;

    state_t                r_state;
    logic [15:0]           r_len;
    logic [PtrW-1:0]       r_cnt;
    logic [7:0]            r_xor;
    logic [TM_BYTES*8-1:0] r_shadow;
    logic [TM_BYTES*8-1:0] r_mem;
    logic                  r_loaded;
    logic                  r_load_pulse;
    logic                  r_err_pulse;
    logic [1:0]            r_err_code;

    logic                  w_fire;
    logic [15:0]           w_len;
    logic                  w_len_bad;
    logic                  w_last;
    logic [IdxW-1:0]       w_idx;

    assign w_fire    = s_in.in_valid && s_in.in_ready;
    assign w_len     = {s_in.in_data, r_len[7:0]};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > 17'(TM_BYTES));
    assign w_last    = ((16'(r_cnt) + 16'd1) == r_len);
    assign w_idx     = IdxW'({r_cnt, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_len        <= '0;
            r_cnt        <= '0;
            r_xor        <= '0;
            r_shadow     <= '0;
            r_mem        <= '0;
            r_loaded     <= 1'b0;
            r_load_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_code   <= 2'b00;
        end else begin
            r_load_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_fire && s_in.in_data == HDR_BYTE) begin
                        r_shadow <= '0;
                        r_cnt    <= '0;
                        r_xor    <= '0;
                        r_state  <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (w_fire) begin
                        r_len[7:0] <= s_in.in_data;
                        r_state    <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (w_fire) begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_err_pulse <= 1'b1;
                            r_err_code  <= 2'b01;
                            r_state     <= StIdle;
                        end else begin
                            r_state <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (w_fire) begin
                        r_shadow[w_idx +: 8] <= s_in.in_data;
                        r_cnt                <= r_cnt + 1'b1;
                        r_xor                <= r_xor ^ s_in.in_data;
                        if (w_last) begin
                            r_state <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (w_fire) begin
                        if (s_in.in_data != r_xor) begin
                            r_err_pulse <= 1'b1;
                            r_err_code  <= 2'b10;
                            r_state     <= StIdle;
                        end else begin
                            r_state <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    r_mem        <= r_shadow;
                    r_loaded     <= 1'b1;
                    r_load_pulse <= 1'b1;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Handshake and busy are pure decodes of the state register.
    assign s_in.in_ready   = (r_state != StCommit);
    assign busy            = (r_state != StIdle);
    assign env_task_memory = r_mem;
    assign loaded          = r_loaded;
    assign load_pulse      = r_load_pulse;
    assign err_pulse       = r_err_pulse;
    assign err_code        = r_err_code;

endmodule

// File: tb/tb_env_loader.sv
// Randomized bench for env_loader; expected images come from a frame-level model.
module tb_env_loader;
    localparam int TM = 256;

    logic              clk;
    logic              reset;
    logic [TM*8-1:0]   env_task_memory;
    logic              loaded;
    logic              load_pulse;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic              busy;

    env_loader_if bus ();

    env_loader #(
        .TM_BYTES(TM),
        .HDR_BYTE(8'hA5)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .s_in           (bus),
        .env_task_memory(env_task_memory),
        .loaded         (loaded),
        .load_pulse     (load_pulse),
        .err_pulse      (err_pulse),
        .err_code       (err_code),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_good = 0;
    int n_ready_low = 0;
    int n_both = 0;
    bit gaps_en = 1'b0;

    // Frame-level reference: committed image bytes, loaded flag, last error code.
    logic [7:0] m_img [TM];
    bit         m_loaded;
    logic [1:0] m_code;
    logic [7:0] pay_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int k_bad;
        k_bad = 0;
        for (int k = 0; k < TM; k++) begin
            if (env_task_memory[k*8 +: 8] !== m_img[k]) begin
                k_bad = k;
                break;
            end
        end
        check(tag, env_task_memory[k_bad*8 +: 8], m_img[k_bad]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < TM; k++) m_img[k] = 8'h00;
        m_loaded = 1'b0;
        m_code   = 2'b00;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.in_ready) n_ready_low++;
            if (err_pulse && load_pulse) n_both++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        int guard;
        @(negedge clk);
        if (gaps_en) begin
            g = $urandom_range(0, 2);
            bus.in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) check("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic fill_random(input int len);
        pay_q.delete();
        for (int k = 0; k < len; k++) pay_q.push_back(8'($urandom));
    endtask

    // Sends HDR, LEN, payload (pay_q) and CHK, then checks the outcome.
    task automatic send_frame(input logic [15:0] len, input int chk_ovr);
        logic [7:0] chk_true;
        logic [7:0] chk_sent;
        bit         len_ok;
        bit         good;
        len_ok = (len != 16'd0) && (int'(len) <= TM);
        send_byte(8'hA5);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        good = 1'b0;
        if (len_ok) begin
            chk_true = 8'h00;
            for (int k = 0; k < int'(len); k++) begin
                send_byte(pay_q[k]);
                chk_true = chk_true ^ pay_q[k];
            end
            chk_sent = (chk_ovr < 0) ? chk_true : chk_ovr[7:0];
            send_byte(chk_sent);
            good = (chk_sent == chk_true);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (good) begin
            n_good++;
            for (int k = 0; k < TM; k++) m_img[k] = (k < int'(len)) ? pay_q[k] : 8'h00;
            m_loaded = 1'b1;
            check("commit_ready", bus.in_ready, 1'b0);
            check("commit_busy", busy, 1'b1);
            check("commit_no_pulse", load_pulse, 1'b0);
            @(negedge clk);
            check("load_pulse", load_pulse, 1'b1);
            check("loaded", loaded, 1'b1);
            check("load_no_err", err_pulse, 1'b0);
            check("load_idle", busy, 1'b0);
            check_mem("image");
            @(negedge clk);
            check("load_pulse_end", load_pulse, 1'b0);
        end else begin
            m_code = len_ok ? 2'b10 : 2'b01;
            check("err_pulse", err_pulse, 1'b1);
            check("err_code", err_code, m_code);
            check("err_no_load", load_pulse, 1'b0);
            check("err_idle", busy, 1'b0);
            check("err_loaded", loaded, m_loaded);
            check_mem("err_image");
            @(negedge clk);
            check("err_pulse_end", err_pulse, 1'b0);
            check("err_code_hold", err_code, m_code);
        end
    endtask

    initial begin
        int kind;
        int len;
        int ovr;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_loaded", loaded, 1'b0);
        check("rst_load_pulse", load_pulse, 1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check_mem("rst_image");

        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(16'd4, -1);
        check("word0", env_task_memory[31:0], 32'h44332211);
        send_frame(16'd4, 8'h00);

        send_frame(16'h0000, -1);
        send_frame(16'h0101, -1);
        pay_q = '{8'h5C, 8'h7E, 8'h01};
        send_frame(16'd3, -1);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("garbage_idle", busy, 1'b0);
        pay_q = '{8'hA5, 8'h01};
        send_frame(16'd2, -1);
        check("word_hdr_data", env_task_memory[15:0], 16'h01A5);

        gaps_en = 1'b1;
        fill_random(8);
        send_frame(16'd8, -1);
        fill_random(2);
        send_frame(16'd2, -1);
        fill_random(TM);
        send_frame(16'(TM), -1);

        for (int i = 0; i < 10; i++) begin
            gaps_en = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_frame(16'h0000, -1);
            end else if (kind == 1) begin
                send_frame(16'(TM + $urandom_range(1, 300)), -1);
            end else begin
                len = $urandom_range(1, 48);
                fill_random(len);
                ovr = (kind < 4) ? $urandom_range(0, 255) : -1;
                send_frame(16'(len), ovr);
            end
        end

        gaps_en = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h00);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_rst_loaded", loaded, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", bus.in_ready, 1'b1);
        check("mid_rst_err_code", err_code, 2'b00);
        check_mem("mid_rst_image");
        fill_random(5);
        send_frame(16'd5, -1);

        check("ready_low_cycles", 64'(n_ready_low), 64'(n_good));
        check("pulse_overlap", 64'(n_both), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/env_loader.md
Name: env_loader

Overview:
- Upstream feeder for the GPU top's task-memory input; replaces the static task-memory image with a runtime-loadable one.
- Receives a framed byte stream over a valid/ready handshake (e.g. from a UART receiver) and assembles it into a shadow buffer.
- After a checksum-verified frame, commits the shadow buffer to the flat env_task_memory bus in one cycle and signals the scheduler side.

Parameters:
- TM_BYTES, 256, task-memory image size in bytes; output bus width is TM_BYTES*8.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte; a byte transfers on a cycle with in_valid && in_ready.
- env_task_memory  output  TM_BYTES*8  committed image; payload byte k occupies bits [8k+7:8k].
- loaded  output  1  level signal: at least one image has been committed since reset.
- load_pulse  output  1  one-cycle pulse in the first cycle a new image is visible.
- err_pulse  output  1  one-cycle pulse when a frame is rejected.
- err_code  output  2  01 = bad length, 10 = bad checksum; held until the next err_pulse or reset.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Single clock domain. All state is updated only on the rising edge of clk. Reset is synchronous, active-high.
- Reset values: state=IDLE, shadow=0, env_task_memory=0, loaded=0, load_pulse=0, err_pulse=0, err_code=00, busy=0, in_ready=1.
- Frame format: HDR_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CHK. CHK is the XOR of all payload bytes only.
- FSM states: IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, COMMIT.
- IDLE: accepts bytes and discards any byte that is not HDR_BYTE.
  - On HDR_BYTE: go to LEN_LO, zero the entire shadow buffer, clear the byte counter and the running XOR.
- LEN_LO: latch the low length byte, go to LEN_HI.
- LEN_HI: latch the high length byte to form a 16-bit LEN.
  - If LEN==0 or LEN>TM_BYTES: err_pulse=1 and err_code=01 in the next cycle, go to IDLE.
  - Otherwise go to PAYLOAD.
- PAYLOAD: write each accepted byte to shadow[cnt], cnt++, running XOR ^= byte.
  - The byte that makes cnt==LEN moves the FSM to CHECK.
- CHECK: the accepted byte is compared with the running XOR.
  - Mismatch: err_pulse=1 and err_code=10 in the next cycle, go to IDLE. env_task_memory is unchanged.
  - Match: go to COMMIT.
- COMMIT: lasts exactly 1 cycle with in_ready=0.
  - At its closing edge: env_task_memory <= shadow, loaded <= 1, load_pulse <= 1, state <= IDLE.
- in_ready is 1 in all states except COMMIT.
- Latency: CHK accepted at edge N puts the FSM in COMMIT during cycle N..N+1. The new image and load_pulse are visible in the cycle after edge N+1.
- Payload bytes beyond LEN remain 0 in the committed image, because the shadow buffer is cleared at the header.
- Stalls: in_valid low for any number of cycles mid-frame changes nothing. There is no timeout.
- A HDR_BYTE value appearing inside PAYLOAD or as CHK is treated as data, not as a resync.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values, including a previously committed image.
- err_pulse and load_pulse are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
- Reset, then frame A5,04,00,11,22,33,44,CHK=44 -> one cycle after COMMIT: env_task_memory[31:0]=32'h44332211, upper bits 0, load_pulse high for 1 cycle, loaded=1.
- Same frame with CHK=00 -> err_pulse for 1 cycle, err_code=10, env_task_memory keeps its previous value, loaded unchanged.
- A5,00,00 and separately A5,01,01 (LEN=257, TM_BYTES=256) -> err_pulse, err_code=01, return to IDLE, following valid frame loads correctly.
- Garbage bytes 00,FF,5A before a valid 2-byte frame A5,02,00,A5,01,A4 -> garbage ignored, image[15:0]=16'h01A5.
- Valid 8-byte frame with in_valid toggled randomly, then a second 2-byte frame -> first image bits cleared above byte 1, in_ready=0 only in the COMMIT cycles.
- Reset asserted mid-PAYLOAD after a prior successful load -> env_task_memory=0, loaded=0, busy=0, next frame loads normally.
